// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the parametrised single-cycle core: opcode values,
// the internal ALU operation encoding, the run/halt state encoding and the
// bit positions of the instruction fields.
package cpu_pkg;

  // Opcode values carried in the top byte of every instruction.
  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;

  // Subtraction reuses ALU_ADD with a negated second operand, so the ALU
  // itself only needs these four operations. ALU_FWD passes operand B through.
  typedef enum logic [1:0] {
    ALU_FWD = 2'd0,
    ALU_ADD = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_op_t;

  // HALT is only left through reset.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  // Low bit of each 8-bit instruction field.
  localparam int OPC_LSB = 24;
  localparam int RD_LSB  = 16;
  localparam int RT_LSB  = 8;
  localparam int RS_LSB  = 0;
  localparam int FIELD_W = 8;

endpackage

// File: rtl/reg_file_p.sv
// reg_file_p
// General-purpose register file: two combinational read ports for the
// datapath, one combinational debug read port and one synchronous write port.
// Ports:
//   CLK                  clock, writes on rising edge
//   RESET                asynchronous active-low clear of every register
//   WE, WADDR, WDATA     write port
//   RADDR_A / RDATA_A    read port A (RT operand)
//   RADDR_B / RDATA_B    read port B (RS operand)
//   DBG_ADDR / DBG_DATA  debug read port
module reg_file_p #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              WE,
  input  logic [ADDR_W-1:0] WADDR,
  input  logic [DATA_W-1:0] WDATA,
  input  logic [ADDR_W-1:0] RADDR_A,
  output logic [DATA_W-1:0] RDATA_A,
  input  logic [ADDR_W-1:0] RADDR_B,
  output logic [DATA_W-1:0] RDATA_B,
  input  logic [ADDR_W-1:0] DBG_ADDR,
  output logic [DATA_W-1:0] DBG_DATA
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Asynchronous clear drops any write that is in flight when reset arrives.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (WE) begin
      regs[WADDR] <= WDATA;
    end
  end

  // Reads see the pre-edge contents, so an instruction may read and write
  // the same register.
  assign RDATA_A  = regs[RADDR_A];
  assign RDATA_B  = regs[RADDR_B];
  assign DBG_DATA = regs[DBG_ADDR];

endmodule

// File: rtl/cpu_core_p.sv
// cpu_core_p
// Parametrised single-cycle core. Owns the PC, the register file and the
// ALU; executes one instruction per rising edge while INSTR_VALID is high,
// and stops permanently on an undefined opcode until reset.
// Ports:
//   CLK          clock
//   RESET        asynchronous active-low reset
//   INSTRUCTION  {opcode, rd/offset, rt, rs/imm}, one byte each
//   INSTR_VALID  instruction is valid for the current PC; stall while low
//   PC           byte address of the current instruction
//   HALTED       core stopped on an illegal opcode
//   RETIRED      saturating count of executed instructions
//   DBG_ADDR     debug register select
//   DBG_DATA     combinational read of the selected register
module cpu_core_p
  import cpu_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int PC_W     = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [31:0]       INSTRUCTION,
  input  logic              INSTR_VALID,
  output logic [PC_W-1:0]   PC,
  output logic              HALTED,
  output logic [31:0]       RETIRED,
  input  logic [ADDR_W-1:0] DBG_ADDR,
  output logic [DATA_W-1:0] DBG_DATA
);

  state_t            state_q, state_next;
  logic [PC_W-1:0]   pc_q, pc_next;
  logic [31:0]       retired_q, retired_next;

  logic [7:0]        opcode;
  logic [7:0]        imm;
  logic [7:0]        offset;
  logic [ADDR_W-1:0] rd_addr, rt_addr, rs_addr;
  logic [DATA_W-1:0] rt_data, rs_data;
  logic [DATA_W-1:0] imm_ext;

  alu_op_t           alu_op;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_y;
  logic              reg_we;
  logic              wr_en;
  logic              illegal;
  logic              is_jump;
  logic              is_beq;
  logic              take_branch;

  logic [PC_W-1:0]   pc_plus4;
  logic [PC_W-1:0]   offset_ext;
  logic [PC_W-1:0]   branch_target;

  // Only the low ADDR_W bits of the RT field select a register.
  logic              unused_rt_bits;

  assign opcode  = INSTRUCTION[OPC_LSB +: FIELD_W];
  assign offset  = INSTRUCTION[RD_LSB  +: FIELD_W];
  assign imm     = INSTRUCTION[RS_LSB  +: FIELD_W];
  assign rd_addr = INSTRUCTION[RD_LSB  +: ADDR_W];
  assign rt_addr = INSTRUCTION[RT_LSB  +: ADDR_W];
  assign rs_addr = INSTRUCTION[RS_LSB  +: ADDR_W];
  assign unused_rt_bits = ^INSTRUCTION[RT_LSB +: FIELD_W];

  // A size cast of a signed value sign-extends; for DATA_W == 8 it is a no-op.
  assign imm_ext    = DATA_W'($signed(imm));
  assign offset_ext = PC_W'($signed(offset));

  // All PC arithmetic wraps naturally at PC_W bits.
  assign pc_plus4      = pc_q + PC_W'(4);
  assign branch_target = pc_plus4 + (offset_ext << 2);

  reg_file_p #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_regs (
    .CLK      (CLK),
    .RESET    (RESET),
    .WE       (wr_en),
    .WADDR    (rd_addr),
    .WDATA    (alu_y),
    .RADDR_A  (rt_addr),
    .RDATA_A  (rt_data),
    .RADDR_B  (rs_addr),
    .RDATA_B  (rs_data),
    .DBG_ADDR (DBG_ADDR),
    .DBG_DATA (DBG_DATA)
  );

  // Decode and ALU. Subtraction is performed as RT + (~RS + 1) through the
  // adder; loadi and mov forward operand B straight to the write port.
  always_comb begin
    alu_op  = ALU_FWD;
    op_b    = rs_data;
    reg_we  = 1'b0;
    illegal = 1'b0;
    is_jump = 1'b0;
    is_beq  = 1'b0;
    alu_y   = '0;
    case (opcode)
      OP_LOADI: begin op_b = imm_ext; reg_we = 1'b1; end
      OP_MOV:   begin reg_we = 1'b1; end
      OP_ADD:   begin alu_op = ALU_ADD; reg_we = 1'b1; end
      OP_SUB:   begin alu_op = ALU_ADD; op_b = ~rs_data + DATA_W'(1); reg_we = 1'b1; end
      OP_AND:   begin alu_op = ALU_AND; reg_we = 1'b1; end
      OP_OR:    begin alu_op = ALU_OR;  reg_we = 1'b1; end
      OP_J:     begin is_jump = 1'b1; end
      OP_BEQ:   begin is_beq = 1'b1; end
      default:  begin illegal = 1'b1; end
    endcase
    case (alu_op)
      ALU_FWD: alu_y = op_b;
      ALU_ADD: alu_y = rt_data + op_b;
      ALU_AND: alu_y = rt_data & op_b;
      ALU_OR:  alu_y = rt_data | op_b;
      default: alu_y = op_b;
    endcase
  end

  assign take_branch = is_jump | (is_beq & (rt_data == rs_data));

  // State register: run/halt state, PC and retired counter all move together.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= ST_RUN;
      pc_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_next;
      pc_q      <= pc_next;
      retired_q <= retired_next;
    end
  end

  // Next-state logic. Nothing changes unless the core is running and the
  // instruction is valid; an illegal opcode only moves the FSM to HALT.
  always_comb begin
    state_next   = state_q;
    pc_next      = pc_q;
    retired_next = retired_q;
    wr_en        = 1'b0;
    if (state_q == ST_RUN && INSTR_VALID) begin
      if (illegal) begin
        state_next = ST_HALT;
      end else begin
        wr_en   = reg_we;
        pc_next = take_branch ? branch_target : pc_plus4;
        if (retired_q != '1) begin
          retired_next = retired_q + 32'd1;
        end
      end
    end
  end

  assign PC      = pc_q;
  assign HALTED  = (state_q == ST_HALT);
  assign RETIRED = retired_q;

endmodule

// File: doc/cpu_core_p.md
Name: cpu_core_p

Overview:
- Parametrised successor to the single-cycle 8-bit CPU.
- Generalises the datapath width and register-file depth.
- Adds instruction-valid handshaking, `j` and `beq` control flow, illegal-opcode halt, a retired-instruction counter, and a register debug read port.
- Sits between instruction memory and the testbench/top, and owns the PC, register file and ALU.

Parameters:
- DATA_W, 8, datapath/register width in bits (8..32).
- NUM_REGS, 8, register count (power of two, 2..256); ADDR_W = clog2(NUM_REGS).
- PC_W, 32, program counter width.

Ports:
- CLK  in  1  system clock; all state updates on its rising edge.
- RESET  in  1  asynchronous, active-low reset.
- INSTRUCTION  in  32  instruction at PC; fields are [31:24] OPCODE, [23:16] RD/OFFSET, [15:8] RT, [7:0] RS/IMM.
- INSTR_VALID  in  1  INSTRUCTION is valid for the current PC; the core stalls while low.
- PC  out  PC_W  byte address of the current instruction.
- HALTED  out  1  core stopped on an illegal opcode.
- RETIRED  out  32  count of instructions executed since reset.
- DBG_ADDR  in  ADDR_W  debug register select.
- DBG_DATA  out  DATA_W  combinational read of register[DBG_ADDR].

Behaviour:
- Reset (RESET low, asynchronous):
  - PC=0, all registers=0, HALTED=0, RETIRED=0, state=RUN.
  - Release takes effect at the first rising edge with RESET high.
  - Reset mid-operation discards any in-flight write.
- State machine has two states, RUN and HALT.
  - RUN→HALT at the edge where INSTR_VALID=1 and OPCODE is undefined. No register write occurs, PC holds, HALTED=1, RETIRED does not increment.
  - HALT is left only by reset.
- Execution rules (single cycle):
  - In RUN with INSTR_VALID=1, the instruction executes at the next rising edge: register write, PC update and RETIRED+1 all happen on the same edge.
  - With INSTR_VALID=0, no state changes.
- Register addressing:
  - Register addresses use field[ADDR_W-1:0]; upper field bits are ignored.
  - Register reads are combinational. Writes are synchronous to CLK.
- IMM: 8 bits, sign-extended to DATA_W. If DATA_W=8 it is used as-is.
- Opcodes:
  - 0x00 loadi: RD=IMM.
  - 0x01 mov: RD=RS.
  - 0x02 add: RD=RT+RS, modulo 2^DATA_W, carry discarded.
  - 0x03 sub: RD=RT+(~RS+1), modulo 2^DATA_W.
  - 0x04 and: RD=RT&RS.
  - 0x05 or: RD=RT|RS.
  - 0x06 j: PC=PC+4+(sext8(OFFSET)<<2); no register write.
  - 0x07 beq: if RT==RS, PC=PC+4+(sext8(OFFSET)<<2), else PC=PC+4; no register write.
  - All other opcodes: illegal (see state machine).
- PC rules:
  - Non-branch instructions: PC=PC+4.
  - All PC arithmetic is modulo 2^PC_W; wrap from 0xFFFFFFFC to 0 is legal.
  - Offset 0xFF (j) makes the instruction jump to itself.
- Counter and debug port:
  - RETIRED saturates at 0xFFFFFFFF.
  - DBG_DATA reflects the register contents after the most recent edge; a same-cycle write becomes visible after that edge.
- The same register may be used as RD and a source; the source value is the pre-edge value.

Decomposition:
- Package cpu_pkg:
  - opcode localparams OP_LOADI..OP_BEQ;
  - ALU op encoding ALU_FWD/ALU_ADD/ALU_AND/ALU_OR;
  - state encoding ST_RUN/ST_HALT;
  - field bit-position constants.
- Sub-module reg_file_p (DATA_W, NUM_REGS):
  - two combinational read ports plus one debug read port;
  - one synchronous write port;
  - asynchronous active-low clear.
- ALU and decode stay inline in cpu_core_p.

Test Plan:
- Reset release, then loadi r1,0x05; loadi r2,0x03; sub r3,r1,r2 with INSTR_VALID=1 → after 3 edges r3=0x02, PC=12, RETIRED=3.
- add r4,r1,r1 with r1=0xFF, DATA_W=8 → r4=0xFE (wrap); loadi r5,0x80 with DATA_W=16 → r5=0xFF80.
- beq r1,r1,offset 0x02 at PC=8 → PC=20; beq with r1≠r2 → PC=12; j offset 0xFF at PC=16 → PC stays 16, RETIRED increments each edge.
- INSTR_VALID held low for 5 cycles mid-program → PC, registers and RETIRED unchanged; the program resumes correctly when INSTR_VALID returns high.
- Opcode 0x2A at PC=4 → HALTED=1 at the next edge, PC stays 4, no write; later valid instructions are ignored until RESET pulses low, after which PC=0 and registers=0.
- Assert RESET low between clock edges during a write cycle → registers/PC clear immediately without waiting for CLK; DBG_DATA reads 0 for every DBG_ADDR.
